// File: rtl/led_rate_scheduler.sv
`timescale 1ns/1ps
// Round-robin time-sharing of one 32-bit prescaler among four LED toggle channels.
// Latency: sw pin to debounced enable 2+DB_CYCLES edges; no backpressure (free-running).
module led_rate_scheduler #(
    parameter int unsigned BASE_DIV     = 25_000_000,
    parameter int unsigned SLOT_TOGGLES = 4,
    parameter int unsigned DB_CYCLES    = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sw,
    output logic [3:0] led,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int unsigned TW  = $clog2(SLOT_TOGGLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, HANDOFF} state_t;

    state_t         state_q, state_d;
    logic [3:0]     sync1_q, sync1_d, sw_s_q, sw_s_d;
    logic [3:0]     sw_db_q, sw_db_d, led_q, led_d, fall;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [31:0]    cnt_q, cnt_d, limit;
    logic [TW-1:0]  tcnt_q, tcnt_d, tcnt_inc;
    logic [1:0]     grant_q, grant_d, last_q, last_d, winner, idx;
    logic           found;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sync1_q  <= 4'd0;
            sw_s_q   <= 4'd0;
            sw_db_q  <= 4'd0;
            db_cnt_q <= '0;
            led_q    <= 4'd0;
            cnt_q    <= 32'd0;
            tcnt_q   <= '0;
            grant_q  <= 2'd0;
            last_q   <= 2'd3;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sw_s_q   <= sw_s_d;
            sw_db_q  <= sw_db_d;
            db_cnt_q <= db_cnt_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    // Synchronizer plus a single shared debounce counter for all four switches.
    always_comb begin
        sync1_d  = sw;
        sw_s_d   = sync1_q;
        sw_db_d  = sw_db_q;
        db_cnt_d = '0;
        if (sw_s_q != sw_db_q) begin
            if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
                sw_db_d = sw_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign fall = sw_db_q & ~sw_db_d;

    // First enabled channel after last_grant; wraps back to last_grant itself.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && sw_db_q[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign limit    = (32'(BASE_DIV) << grant_q) - 32'd1;
    assign tcnt_inc = tcnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        led_d   = led_q & ~fall;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (sw_db_q != 4'd0) state_d = HANDOFF;
            end
            HANDOFF: begin
                cnt_d  = 32'd0;
                tcnt_d = '0;
                if (sw_db_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    grant_d = winner;
                    last_d  = winner;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A disabled owner abandons the slot; this also beats a coincident toggle.
                if (!sw_db_d[grant_q]) begin
                    state_d = HANDOFF;
                end else if (cnt_q == limit) begin
                    led_d[grant_q] = ~led_q[grant_q];
                    cnt_d          = 32'd0;
                    tcnt_d         = tcnt_inc;
                    if (tcnt_inc == TW'(SLOT_TOGGLES)) state_d = HANDOFF;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign led   = led_q;
    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/led_rate_scheduler.md
Name: led_rate_scheduler

Overview:
- Time-shares one prescaler counter between four LED toggle channels.
- Channel i toggles led[i] every BASE_DIV<<i clocks (25M/50M/100M/200M at default) and requests service while sw[i] is on.
- A round-robin scheduler grants the counter to one enabled channel at a time, for SLOT_TOGGLES toggles.
- Sits between the board switches and LEDs on the PL side, replacing per-channel free-running counters.

Parameters:
- BASE_DIV, 25_000_000, channel-0 toggle period in clocks; channel i period = BASE_DIV<<i; BASE_DIV<<3 must fit in 32 bits.
- SLOT_TOGGLES, 4, toggles a granted channel performs before handoff (>=1).
- DB_CYCLES, 1_000_000, consecutive stable cycles required before a switch change is accepted (>=1).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- sw  input  4  raw, asynchronous switch inputs; bit i enables channel i.
- led  output  4  LED drive; bit i is owned by channel i.
- grant  output  2  currently granted channel index.
- busy  output  1  1 while in RUN or HANDOFF.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: led=0, grant=0, busy=0.
  - Internal: sync flops=0, sw_db=0, debounce counter=0, prescaler cnt=0, toggle count tcnt=0, last_grant=3, state=IDLE.
- Input conditioning:
  - sw passes through a 2-flop synchronizer to produce sw_s.
  - Debounce: one shared counter runs while sw_s != sw_db and clears when they are equal.
  - When the counter reaches DB_CYCLES, sw_db <= sw_s and the counter clears.
  - Latency from a pin change to sw_db is 2+DB_CYCLES edges.
  - A glitch shorter than DB_CYCLES is ignored.
- FSM states: IDLE, RUN, HANDOFF.
- IDLE:
  - busy=0, cnt=0.
  - If sw_db != 0, go to HANDOFF.
- HANDOFF (exactly 1 cycle):
  - Round-robin search from last_grant+1 mod 4 upward; the first enabled bit wins.
  - grant <= winner, last_grant <= winner, cnt=0, tcnt=0, then go to RUN.
  - If sw_db == 0, go to IDLE instead.
  - If only the previous channel is enabled, it is re-granted to itself.
- RUN:
  - cnt increments every cycle.
  - When cnt == (BASE_DIV<<grant)-1: led[grant] toggles, cnt <= 0, tcnt increments.
  - Once that toggle is toggle number SLOT_TOGGLES, go to HANDOFF.
  - Non-granted leds hold their value while their sw_db bit stays 1.
- Channel disable (any state, any channel):
  - When sw_db[i] falls, led[i] <= 0 on the same edge.
  - If i == grant in RUN, abandon the slot: go to HANDOFF, with no toggle on that edge.
- All switches off:
  - Reached via HANDOFF, then IDLE; led=0 and busy=0.
- Arithmetic:
  - cnt is 32 bits and never wraps; the compare is exact.
  - tcnt is sized for SLOT_TOGGLES.
- Simultaneous events:
  - If sw_db[grant] falls on a toggle edge, the disable wins: led cleared, no toggle.
  - If a new channel is enabled mid-slot, it waits for the next HANDOFF.
- Reset mid-operation returns every register to its reset value immediately.

Test Plan (BASE_DIV=2, SLOT_TOGGLES=2, DB_CYCLES=3):
1. Hold reset_n=0 with sw=4'hF and clock toggling, then pulse reset_n low mid-RUN -> led=0, grant=0, busy=0 asynchronously, without waiting for a clock edge.
2. sw=0001 -> 5 edges later sw_db=0001; after HANDOFF, grant=0, busy=1; led[0] toggles every 2 clocks indefinitely; a 1-cycle HANDOFF appears after every 2 toggles with grant staying 0.
3. sw=0101:
   - grant sequence is 0,2,0,2...
   - ch0 slot: 2 toggles at 2-clock spacing.
   - ch2 slot: 2 toggles at 8-clock spacing.
   - led[0] holds its last value during ch2 slots.
4. sw[1] pulsed high for 2 cycles then low -> sw_db stays 0000, state stays IDLE, led=0.
5. sw 0011 -> 0010 while grant=0 mid-slot -> on the sw_db update, led[0]=0; next cycle is HANDOFF; then grant=1 and led[1] toggles every 4 clocks.
6. All switches off from RUN with sw=1111 -> after debounce: led=0000, HANDOFF, IDLE, busy=0, grant holds its last value.
